// File: rtl/cmem_arbiter.sv
// Three-requester arbiter in front of the convolution result memory.
// Round-robin by default; define CMEM_ARB_FIXPRI_EN for fixed priority (0 > 1 > 2).
module cmem_arbiter #(
    parameter int unsigned DW = 20,
    parameter int unsigned AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [8:0]        sel,
    input  logic [3*AW-1:0]   addr,
    input  logic [3*DW-1:0]   wdata,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic              cwr,
    output logic              crd,
    output logic [2:0]        csel,
    output logic [AW-1:0]     caddr_wr,
    output logic [AW-1:0]     caddr_rd,
    output logic [DW-1:0]     cdata_wr,
    input  logic [DW-1:0]     cdata_rd
);

    logic [2:0][2:0]    sel_a;
    logic [2:0][AW-1:0] addr_a;
    logic [2:0][DW-1:0] wdata_a;

    assign sel_a   = sel;
    assign addr_a  = addr;
    assign wdata_a = wdata;

    logic       win_any;
    logic [1:0] win_idx;
    logic [2:0] w_sel;
    logic       w_legal;

    logic          cwr_q, cwr_d, crd_q, crd_d, err_q, err_d;
    logic [2:0]    csel_q, csel_d, rid_q, rid_d, rvalid_q, rvalid_d;
    logic [AW-1:0] caw_q, caw_d, car_q, car_d;
    logic [DW-1:0] cdw_q, cdw_d, rdata_q, rdata_d;

`ifdef CMEM_ARB_FIXPRI_EN
    always_comb begin
        win_any = 1'b0;
        win_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!win_any && req[k]) begin
                win_any = 1'b1;
                win_idx = 2'(k);
            end
        end
        if (reset) win_any = 1'b0;
    end
`else
    logic [1:0] p_q, p_d;
    logic [2:0] sum;

    // Search starts at the pointer and wraps modulo 3.
    always_comb begin
        win_any = 1'b0;
        win_idx = 2'd0;
        sum     = 3'd0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, p_q} + 3'(k);
            if (sum >= 3'd3) sum = sum - 3'd3;
            if (!win_any && req[sum[1:0]]) begin
                win_any = 1'b1;
                win_idx = sum[1:0];
            end
        end
        if (reset) win_any = 1'b0;
        p_d = p_q;
        if (win_any) p_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) p_q <= 2'd0;
        else       p_q <= p_d;
    end
`endif

    always_comb begin
        gnt     = win_any ? (3'b001 << win_idx) : 3'b000;
        w_sel   = sel_a[win_idx];
        w_legal = (w_sel != 3'd0) && (w_sel <= 3'd5);
    end

    always_comb begin
        cwr_d    = 1'b0;
        crd_d    = 1'b0;
        err_d    = 1'b0;
        rid_d    = 3'b000;
        csel_d   = csel_q;
        caw_d    = caw_q;
        car_d    = car_q;
        cdw_d    = cdw_q;
        // Read issued last cycle: memory data is valid now, return it next cycle.
        rvalid_d = crd_q ? rid_q : 3'b000;
        rdata_d  = crd_q ? cdata_rd : rdata_q;
        if (win_any) begin
            if (!w_legal) begin
                err_d = 1'b1;
            end else begin
                csel_d = w_sel;
                if (we[win_idx]) begin
                    cwr_d = 1'b1;
                    caw_d = addr_a[win_idx];
                    cdw_d = wdata_a[win_idx];
                end else begin
                    crd_d = 1'b1;
                    car_d = addr_a[win_idx];
                    rid_d = gnt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cwr_q    <= 1'b0;
            crd_q    <= 1'b0;
            err_q    <= 1'b0;
            csel_q   <= 3'b000;
            rid_q    <= 3'b000;
            rvalid_q <= 3'b000;
            caw_q    <= '0;
            car_q    <= '0;
            cdw_q    <= '0;
            rdata_q  <= '0;
        end else begin
            cwr_q    <= cwr_d;
            crd_q    <= crd_d;
            err_q    <= err_d;
            csel_q   <= csel_d;
            rid_q    <= rid_d;
            rvalid_q <= rvalid_d;
            caw_q    <= caw_d;
            car_q    <= car_d;
            cdw_q    <= cdw_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign err      = err_q;
    assign csel     = csel_q;
    assign caddr_wr = caw_q;
    assign caddr_rd = car_q;
    assign cdata_wr = cdw_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;

endmodule

// File: doc/cmem_arbiter.md
CMEM_ARBITER -- requirements
Module: cmem_arbiter

Interface
REQ-001 Parameter DW, default 20: pixel data width.
REQ-002 Parameter AW, default 12: result-memory address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1: single clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-high.
- req  in  3: per-requester access request. Bit 0 = conv writer, bit 1 = pool engine, bit 2 = flatten engine.
- we  in  3: per-requester direction (1 = write, 0 = read).
- sel  in  9: per-requester memory select, 3 bits each; requester i uses bits [3i+2:3i].
- addr  in  3*AW: per-requester address, AW bits each.
- wdata  in  3*DW: per-requester write data, DW bits each.
- gnt  out  3: one-hot grant, combinational, same cycle as req.
- rvalid  out  3: one-hot read-return strobe.
- rdata  out  DW: read data shared by all requesters, qualified by rvalid.
- err  out  1: one-cycle pulse on an illegal select.
- cwr  out  1: memory write strobe.
- crd  out  1: memory read strobe.
- csel  out  3: memory select (001 L0k0, 010 L0k1, 011 L1k0, 100 L1k1, 101 L2).
- caddr_wr  out  AW: memory write address.
- caddr_rd  out  AW: memory read address.
- cdata_wr  out  DW: memory write data.
- cdata_rd  in  DW: memory read data.

Function
REQ-004 gnt SHALL be one-hot or zero; at most one grant per cycle; gnt[i] only when req[i]=1.
REQ-005 Default arbitration SHALL be round-robin. Pointer p in {0,1,2}; search order p, p+1, p+2 (mod 3); after a grant to i, p becomes (i+1) mod 3. p is unchanged on idle cycles.
REQ-006 Grant in cycle N SHALL register the winner's fields, so cwr/crd/csel/addresses/cdata_wr are driven in cycle N+1.
REQ-007 Write grant: cwr=1, crd=0, caddr_wr=addr, cdata_wr=wdata in N+1. caddr_rd holds its previous value.
REQ-008 Read grant: crd=1, cwr=0, caddr_rd=addr in N+1. cdata_rd is captured at the end of N+1; rdata and rvalid[i]=1 are valid in N+2 for exactly one cycle.
REQ-009 Back-to-back grants every cycle SHALL be supported. Read returns stay in grant order, with at most one in flight per stage.
REQ-010 With no grant, cwr=crd=0 in the next cycle. csel and the addresses hold their last values.
REQ-011 An illegal sel (000, 110, 111) is still granted and rotates the pointer. cwr=crd=0, csel holds, err=1 in N+1, and no rvalid follows.
REQ-012 A requester SHALL hold req/we/sel/addr/wdata stable until gnt is seen. A req drop before grant is legal and simply not serviced.
REQ-013 The block has no address arithmetic: addresses and data pass through unmodified at AW/DW width.

Reset
REQ-014 When reset=1 at a rising edge, the next cycle SHALL show:
- gnt=0, rvalid=0, err=0, cwr=0, crd=0
- csel=000, caddr_wr=0, caddr_rd=0, cdata_wr=0, rdata=0
- p=0
REQ-015 Reset mid-operation SHALL discard any registered access and pending read return. A read granted in the cycle reset is asserted produces no rvalid.
REQ-016 gnt SHALL be forced to 0 while reset=1.

Configuration
REQ-017 Macro CMEM_ARB_FIXPRI_EN controls the arbitration policy:
- Defined: fixed priority, requester 0 > 1 > 2; pointer p is not implemented.
- Undefined: round-robin per REQ-005.
All other behaviour is identical in both builds.

Verification
REQ-018 Single write: req=001, we=001, sel0=001, addr0=0x0A5, wdata0=0x12345 -> gnt=001 in N; cwr=1, csel=001, caddr_wr=0x0A5, cdata_wr=0x12345 in N+1.
REQ-019 Single read: req=010, we=000, sel1=011, addr1=0x3FF, memory holds 0x0ABCD -> crd=1 and caddr_rd=0x3FF in N+1; rvalid=010 and rdata=0x0ABCD in N+2.
REQ-020 All three requesters held continuously from reset:
- Round-robin build: gnt sequence 001, 010, 100, 001, ...
- CMEM_ARB_FIXPRI_EN build: gnt=001 every cycle.
REQ-021 Illegal select: req=100, sel2=111 -> gnt=100 in N; err=1 and cwr=crd=0 in N+1; no rvalid in N+2.
REQ-022 Reset during read: read granted in N, reset=1 in N+1 -> rvalid=0 in N+2 and all outputs at reset values.
REQ-023 Idle: req=000 for 5 cycles after traffic -> cwr=crd=0, gnt=0, and the pointer is unchanged (next grant follows the last-granted+1 rule).
